// File: rtl/tl_pkg.sv
// Shared types and constants for the adaptive traffic-light controller.
package tl_pkg;

    // Phase encoding as seen on the phase output
    typedef enum logic [1:0] {
        PhIdle   = 2'd0,
        PhGreen  = 2'd1,
        PhYellow = 2'd2,
        PhAllRed = 2'd3
    } phase_e;

    // Lamp bit values inside the one-hot green/yellow vectors
    localparam logic LampOn  = 1'b1;
    localparam logic LampOff = 1'b0;

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin lane selector: first requesting lane at or above ptr, wrapping to 0.
module tl_rr_arbiter #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0]         req,
    input  logic [$clog2(NumReq)-1:0] ptr,
    output logic                      valid,
    output logic [$clog2(NumReq)-1:0] grant
);

    localparam int unsigned IdxW = $clog2(NumReq);

    // Scan NumReq positions starting at ptr; the first hit wins
    always_comb begin
        int unsigned idx;
        valid = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/adaptive_tl_ctrl.sv
// Adaptive traffic-light controller: round-robin lane service with
// congestion-extended green (MIN_GREEN..MAX_GREEN), fixed yellow and all-red.
// Optional macro EMERGENCY_PREEMPT_EN adds the emerg_req port and preemption.
module adaptive_tl_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned TW          = 8,
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned MAX_GREEN   = 16,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES-1:0]         start_sns,
    input  logic [NUM_LANES-1:0]         cong_sns,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic [NUM_LANES-1:0]         emerg_req,
`endif
    output logic [1:0]                   phase,
    output logic [$clog2(NUM_LANES)-1:0] active_lane,
    output logic [NUM_LANES-1:0]         green,
    output logic [NUM_LANES-1:0]         yellow
);

    localparam int unsigned LaneW = $clog2(NUM_LANES);

    // Timer holds (cycles spent in phase - 1); these are the last-cycle values
    localparam logic [TW-1:0]    MinLast  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0]    MaxLast  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0]    YelLast  = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0]    ArLast   = TW'(ALLRED_TIME - 1);
    localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_LANES - 1);

    phase_e               phase_q, phase_d;
    logic [LaneW-1:0]     lane_q, lane_d;
    logic [LaneW-1:0]     rr_q, rr_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_LANES-1:0] green_q, green_d;
    logic [NUM_LANES-1:0] yellow_q, yellow_d;

    logic                 arb_valid;
    logic [LaneW-1:0]     arb_grant;
    logic                 green_done;

    tl_rr_arbiter #(
        .NumReq (NUM_LANES)
    ) u_arb (
        .req   (start_sns),
        .ptr   (rr_q),
        .valid (arb_valid),
        .grant (arb_grant)
    );

`ifdef EMERGENCY_PREEMPT_EN
    logic             emerg_any;
    logic [LaneW-1:0] emerg_lane;

    // Lowest-index emergency requester
    always_comb begin
        emerg_any  = |emerg_req;
        emerg_lane = '0;
        for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
            if (emerg_req[i]) begin
                emerg_lane = LaneW'(i);
            end
        end
    end
`endif

    // Decide whether the current green cycle is the last one
    always_comb begin
        green_done = ((timer_q >= MinLast) && (cong_sns[lane_q] == 1'b0)) ||
                     (timer_q >= MaxLast);
`ifdef EMERGENCY_PREEMPT_EN
        // Emergency overrides both MIN_GREEN and MAX_GREEN
        if (emerg_any) begin
            green_done = (emerg_lane != lane_q);
        end
`endif
    end

    // Next-state logic: phase, owning lane and round-robin pointer
    always_comb begin
        phase_d = phase_q;
        lane_d  = lane_q;
        rr_d    = rr_q;
        unique case (phase_q)
            PhIdle: begin
`ifdef EMERGENCY_PREEMPT_EN
                if (emerg_any) begin
                    phase_d = PhGreen;
                    lane_d  = emerg_lane;
                end else
`endif
                if (arb_valid) begin
                    phase_d = PhGreen;
                    lane_d  = arb_grant;
                    rr_d    = (arb_grant == LastLane) ? '0 : arb_grant + 1'b1;
                end
            end
            PhGreen: begin
                if (green_done) phase_d = PhYellow;
            end
            PhYellow: begin
                if (timer_q == YelLast) phase_d = PhAllRed;
            end
            PhAllRed: begin
                if (timer_q == ArLast) phase_d = PhIdle;
            end
            default: phase_d = PhIdle;
        endcase
    end

    // Phase timer: restart on every phase change, saturate instead of wrapping
    always_comb begin
        if (phase_d != phase_q) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Lamp outputs derived from the next phase so they register alongside it
    always_comb begin
        green_d  = {NUM_LANES{LampOff}};
        yellow_d = {NUM_LANES{LampOff}};
        if (phase_d == PhGreen)  green_d[lane_d]  = LampOn;
        if (phase_d == PhYellow) yellow_d[lane_d] = LampOn;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PhIdle;
            lane_q   <= '0;
            rr_q     <= '0;
            timer_q  <= '0;
            green_q  <= '0;
            yellow_q <= '0;
        end else begin
            phase_q  <= phase_d;
            lane_q   <= lane_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
        end
    end

    assign phase       = phase_q;
    assign active_lane = lane_q;
    assign green       = green_q;
    assign yellow      = yellow_q;

endmodule

// File: tb/tb_adaptive_tl_ctrl.sv
// Scoreboard bench for adaptive_tl_ctrl: each service is predicted as a list of
// (phase, lane, length) segments; a monitor measures the segments the DUT shows.
module tb_adaptive_tl_ctrl;

    localparam int N   = 4;
    localparam int MIN = 4;
    localparam int MAX = 16;
    localparam int YEL = 3;
    localparam int AR  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_sns;
    logic [3:0] cong_sns;
`ifdef EMERGENCY_PREEMPT_EN
    logic [3:0] emerg_req;
`endif
    logic [1:0] phase;
    logic [1:0] active_lane;
    logic [3:0] green;
    logic [3:0] yellow;

    adaptive_tl_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_sns   (start_sns),
        .cong_sns    (cong_sns),
`ifdef EMERGENCY_PREEMPT_EN
        .emerg_req   (emerg_req),
`endif
        .phase       (phase),
        .active_lane (active_lane),
        .green       (green),
        .yellow      (yellow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int lane;
        int len;
    } seg_t;

    seg_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   rr_m  = 0;
    bit   mon_en = 1'b0;
    int   run_ph, run_lane;
    int   run_len = 0;
    logic [3:0] exp_g, exp_y;

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic close_run();
        seg_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL segment: got phase=%0d lane=%0d len=%0d, required nothing",
                     run_ph, run_lane, run_len);
        end else begin
            e = exp_q.pop_front();
            if (e.ph != run_ph || e.len != run_len || (e.ph != 0 && e.lane != run_lane)) begin
                bad++;
                $display("FAIL segment: got phase=%0d lane=%0d len=%0d, required phase=%0d lane=%0d len=%0d",
                         run_ph, run_lane, run_len, e.ph, e.lane, e.len);
            end
        end
    endtask

    // Monitor: lamp consistency every cycle, segment check on every phase change
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            run_len = 0;
        end else begin
            exp_g = (phase == 2'd1) ? (4'b0001 << active_lane) : 4'b0000;
            exp_y = (phase == 2'd2) ? (4'b0001 << active_lane) : 4'b0000;
            total++;
            if (green !== exp_g || yellow !== exp_y) begin
                bad++;
                $display("FAIL lamps: phase=%0d lane=%0d green=%b yellow=%b, required green=%b yellow=%b",
                         phase, active_lane, green, yellow, exp_g, exp_y);
            end
            if (run_len != 0 && int'(phase) != run_ph) close_run();
            if (run_len == 0 || int'(phase) != run_ph) begin
                run_ph   = int'(phase);
                run_lane = int'(active_lane);
                run_len  = 1;
            end else begin
                run_len++;
            end
        end
    end

    function automatic int pick(input logic [3:0] m);
        for (int k = 0; k < N; k++) begin
            int l = (rr_m + k) % N;
            if (m[l]) return l;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] s, input logic [3:0] c);
        start_sns = s;
        cong_sns  = c;
        @(posedge clk);
        #1;
    endtask

    // One service: gap idle cycles, request, then green/yellow/all-red.
    // Congestion on the served lane is held for the first d green cycles.
    task automatic txn(input logic [3:0] mask, input int gap, input int d);
        int lane, glen;
        logic [3:0] c;
        lane = pick(mask);
        rr_m = (lane + 1) % N;
        glen = (d + 1 < MIN) ? MIN : d + 1;
        if (glen > MAX) glen = MAX;
        exp_q.push_back('{0, 0, gap + 1});
        exp_q.push_back('{1, lane, glen});
        exp_q.push_back('{2, lane, YEL});
        exp_q.push_back('{3, lane, AR});
        repeat (gap) step(4'b0000, 4'($urandom));
        step(mask, 4'($urandom));
        for (int k = 1; k <= glen; k++) begin
            c = 4'($urandom);
            c[lane] = (k <= d);
            step(4'($urandom), c);
        end
        repeat (YEL + AR) step(4'($urandom), 4'($urandom));
    endtask

    initial begin
        rst       = 1'b1;
        start_sns = '0;
        cong_sns  = '0;
`ifdef EMERGENCY_PREEMPT_EN
        emerg_req = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_phase", int'(phase), 0);
        chk("reset_lane", int'(active_lane), 0);
        chk("reset_green", int'(green), 0);
        chk("reset_yellow", int'(yellow), 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Full demand, no congestion: 0,1,2,3,0 at minimum green
        repeat (5) txn(4'b1111, 0, 0);
        // Lone congested lane forced out at MAX_GREEN
        txn(4'b0100, 1, 30);
        // Long stretch of no demand
        txn(4'b0010, 12, 0);
        // Lane 3 then wrap-around to lane 0
        txn(4'b1000, 0, 0);
        txn(4'b1001, 0, 2);
        // Random traffic
        repeat (40) txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 19));
        repeat (3) step(4'b0000, 4'b0000);
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the second yellow cycle
        step(4'b0100, 4'b0000);
        repeat (MIN) step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        chk("pre_reset_phase", int'(phase), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_lane", int'(active_lane), 0);
        chk("async_rst_green", int'(green), 0);
        chk("async_rst_yellow", int'(yellow), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        // First edge after release arbitrates from pointer 0
        step(4'b1111, 4'b0000);
        chk("post_rst_phase", int'(phase), 1);
        chk("post_rst_lane", int'(active_lane), 0);

`ifdef EMERGENCY_PREEMPT_EN
        emerg_req = 4'b0100;
        step(4'b0000, 4'b0000);
        chk("preempt_phase", int'(phase), 2);
        chk("preempt_lane", int'(active_lane), 0);
        repeat (YEL + AR + 1) step(4'b1111, 4'b0000);
        chk("emerg_green_phase", int'(phase), 1);
        chk("emerg_green_lane", int'(active_lane), 2);
        repeat (20) step(4'b1111, 4'b0000);
        chk("emerg_hold_phase", int'(phase), 1);
        chk("emerg_hold_lane", int'(active_lane), 2);
        emerg_req = 4'b0000;
        step(4'b0000, 4'b0000);
        chk("emerg_release_phase", int'(phase), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
